// File: rtl/supbd_pkg.sv
// Shared definitions for the supplementary bubble data transmitter.
package supbd_pkg;

  localparam int SUPBD_LEN_DEF = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SHIFT = 2'd2,
    ST_ENDP  = 2'd3
  } supbd_st_e;

endpackage

// File: rtl/mdl_supbdtx_shifter.sv
// Shift register, bit counter and running parity for one transfer.
module mdl_supbdtx_shifter #(
  parameter int LEN = supbd_pkg::SUPBD_LEN_DEF
) (
  input  logic           i_MCLK,
  input  logic           i_RST,
  input  logic           clr,
  input  logic           load,
  input  logic           shift,
  input  logic [LEN-1:0] data,
  output logic           msb,
  output logic           cnt_zero,
  output logic           parity
);

  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;

  logic [LEN-1:0] sreg;
  logic [CW-1:0]  cnt;

  assign msb      = sreg[LEN-1];
  assign cnt_zero = (cnt == '0);

  // Load on accept, shift MSB-first on each emitted bit; counter saturates at 0.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      sreg   <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (clr) begin
      sreg   <= '0;
      cnt    <= '0;
      parity <= 1'b0;
    end else if (load) begin
      sreg   <= data;
      cnt    <= CW'(LEN - 1);
      parity <= 1'b1;
    end else if (shift) begin
      sreg   <= {sreg[LEN-2:0], 1'b0};
      parity <= parity ^ sreg[LEN-1];
      if (!cnt_zero) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/mdl_supbdtx.sv
// Supplementary bubble data serial transmitter: START pulse, MSB-first
// bit stream on bit-slot strobes, END pulse carrying odd parity.
module mdl_supbdtx
  import supbd_pkg::*;
#(
  parameter int SUPBD_LEN = SUPBD_LEN_DEF
) (
  input  logic                 i_MCLK,
  input  logic                 i_RST,
  input  logic                 i_CLK2M_PCEN_n,
  input  logic                 i_SYS_RUN_FLAG,
  input  logic                 i_LOAD,
  input  logic [SUPBD_LEN-1:0] i_DATA,
  input  logic                 i_BITSLOT,
  output logic                 o_SUPBD_START_n,
  output logic                 o_SUPBD_ACT_n,
  output logic                 o_SUPBD_DOUT,
  output logic                 o_SUPBD_STB,
  output logic                 o_SUPBD_END_n,
  output logic                 o_PARITY,
  output logic                 o_BUSY
);

  supbd_st_e state, state_nxt;
  logic      step, ld, sh, clr;
  logic      msb, cnt_zero, par;

  assign step   = ~i_CLK2M_PCEN_n;
  assign o_BUSY = (state != ST_IDLE);

  mdl_supbdtx_shifter #(.LEN(SUPBD_LEN)) u_shifter (
    .i_MCLK   (i_MCLK),
    .i_RST    (i_RST),
    .clr      (clr),
    .load     (ld),
    .shift    (sh),
    .data     (i_DATA),
    .msb      (msb),
    .cnt_zero (cnt_zero),
    .parity   (par)
  );

  // Next state and shifter controls; a dropped run flag overrides everything.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    sh        = 1'b0;
    clr       = 1'b0;
    if (step) begin
      if (!i_SYS_RUN_FLAG) begin
        state_nxt = ST_IDLE;
        clr       = 1'b1;
      end else begin
        case (state)
          ST_IDLE:  if (i_LOAD) begin
                      state_nxt = ST_START;
                      ld        = 1'b1;
                    end
          ST_START: state_nxt = ST_SHIFT;
          ST_SHIFT: if (i_BITSLOT) begin
                      sh = 1'b1;
                      if (cnt_zero) state_nxt = ST_ENDP;
                    end
          ST_ENDP:  state_nxt = ST_IDLE;
          default:  state_nxt = ST_IDLE;
        endcase
      end
    end
  end

  // State register.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Registered outputs follow the state being entered, so they hold between steps.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      o_SUPBD_START_n <= 1'b1;
      o_SUPBD_ACT_n   <= 1'b1;
      o_SUPBD_END_n   <= 1'b1;
      o_SUPBD_DOUT    <= 1'b0;
      o_SUPBD_STB     <= 1'b0;
      o_PARITY        <= 1'b0;
    end else if (step) begin
      o_SUPBD_START_n <= (state_nxt != ST_START);
      o_SUPBD_ACT_n   <= (state_nxt == ST_IDLE);
      o_SUPBD_END_n   <= (state_nxt != ST_ENDP);
      o_SUPBD_DOUT    <= sh & msb;
      o_SUPBD_STB     <= sh;
      // Final parity folds in the last bit as it leaves the register.
      o_PARITY        <= (sh && cnt_zero) ? (par ^ msb) : 1'b0;
    end
  end

endmodule

// File: doc/mdl_supbdtx.md
MDL_SUPBDTX -- requirements
Module: mdl_supbdtx

Interface
REQ-001 Parameter SUPBD_LEN, default 14, SHALL set the number of supplementary bubble data bits sent per transfer.
REQ-002 Port i_MCLK  input  1  SHALL be the master clock; all state SHALL change on its rising edge.
REQ-003 Port i_RST  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 Port i_CLK2M_PCEN_n  input  1  SHALL be the active-low clock enable; a "step" is an i_MCLK edge with it low.
REQ-005 Port i_SYS_RUN_FLAG  input  1  SHALL be the system-run qualifier; low aborts any transfer.
REQ-006 Port i_LOAD  input  1  SHALL be the transfer request, sampled on a step.
REQ-007 Port i_DATA  input  SUPBD_LEN  SHALL be the word to send; it is captured on the accepted step.
REQ-008 Port i_BITSLOT  input  1  SHALL be the pre-decoded bit-slot strobe; one bit is emitted per step with it high.
REQ-009 Port o_SUPBD_START_n  output  1  SHALL be the active-low start pulse toward the length counter.
REQ-010 Port o_SUPBD_ACT_n  output  1  SHALL be the active-low transfer-active flag.
REQ-011 Port o_SUPBD_DOUT  output  1  SHALL be the serial data bit, MSB first.
REQ-012 Port o_SUPBD_STB  output  1  SHALL be the write strobe; it is high for the step in which o_SUPBD_DOUT is valid.
REQ-013 Port o_SUPBD_END_n  output  1  SHALL be the active-low end-of-transfer pulse.
REQ-014 Port o_PARITY  output  1  SHALL be the odd parity of the emitted bits; it is valid while o_SUPBD_END_n is low.
REQ-015 Port o_BUSY  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have four states: IDLE, START, SHIFT and ENDP, and SHALL advance only on steps.
REQ-017 IDLE->START SHALL occur when i_LOAD=1 and i_SYS_RUN_FLAG=1; i_DATA is loaded into the shift register, the bit counter is set to SUPBD_LEN-1 and parity is set to 1.
REQ-018 START SHALL last exactly one step, with o_SUPBD_START_n=0, and then go to SHIFT.
REQ-019 In SHIFT, each step with i_BITSLOT=1 SHALL register o_SUPBD_DOUT=sreg[MSB] and o_SUPBD_STB=1, shift the register left, XOR the bit into parity and decrement the counter.
REQ-020 In SHIFT, steps with i_BITSLOT=0 SHALL drive o_SUPBD_STB=0 and hold all state.
REQ-021 An emission with counter=0 SHALL go to ENDP; the counter SHALL NOT wrap.
REQ-022 ENDP SHALL last one step, with o_SUPBD_END_n=0 and o_PARITY presented, then return to IDLE.
REQ-023 o_SUPBD_ACT_n SHALL be 0 from entry to START through the ENDP step inclusive, and 1 otherwise.
REQ-024 i_LOAD outside IDLE SHALL be ignored; it is not queued.
REQ-025 i_SYS_RUN_FLAG=0 on any step SHALL force IDLE with all outputs at their reset values and no END pulse, overriding all other inputs.
REQ-026 A step taken while in ENDP with i_LOAD=1 SHALL NOT start a transfer; new starts are accepted only from IDLE.
REQ-027 Between steps, all outputs SHALL hold.

Reset
REQ-028 On i_RST=1 the block SHALL asynchronously enter IDLE and clear the shift register, counter and parity.
REQ-029 Reset output values SHALL be: o_SUPBD_START_n=1, o_SUPBD_ACT_n=1, o_SUPBD_END_n=1, o_SUPBD_DOUT=0, o_SUPBD_STB=0, o_PARITY=0, o_BUSY=0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer without producing an END pulse.

Structure
REQ-031 The shared package supbd_pkg SHALL hold SUPBD_LEN_DEF=14 and the FSM state encoding.
REQ-032 The shift register, counter and parity SHALL be one sub-module, mdl_supbdtx_shifter; the FSM and output registers SHALL live in the top module.

Verification
REQ-033 Load i_DATA=14'h2A5C with i_BITSLOT held high -> START_n low 1 step, then 14 STB steps with DOUT=1,0,1,0,1,0,0,1,0,1,1,1,0,0, then END_n low 1 step with PARITY=0, then BUSY=0.
REQ-034 Same load with i_BITSLOT high on every 3rd step -> the same 14 bits, the first STB 3 steps after START, and END_n after the 14th STB.
REQ-035 i_LOAD re-asserted during SHIFT with i_DATA=14'h3FFF -> ignored; the output stream stays 14'h2A5C.
REQ-036 i_SYS_RUN_FLAG dropped after the 5th bit -> next step IDLE, ACT_n=1, no END_n pulse; a following load of 14'h0001 -> 13 zeros then a 1, PARITY=0.
REQ-037 i_RST pulsed mid-SHIFT, including between MCLK edges -> outputs immediately at reset values; i_CLK2M_PCEN_n held high -> no state change for 100 MCLK cycles.
